pipe_hazard_ctrl: RTL and testbench
===================================

# pipe_hazard_ctrl

Pipeline sequencing controller for the five-stage core. It drives the IF/ID write enable (IIWrite), the IF/ID flush, the PC write enable and the ID/EX bubble select. It resolves four stall and flush sources: load-use hazards, instruction-memory wait states, multi-cycle multiply/divide occupancy and taken branches. It sits beside the IF/ID and ID/EX pipeline registers and also keeps a saturating stall-cycle performance counter.

## Interface
Parameters:
- MD_LATENCY, 32: stall cycles inserted after a mult/div issues (legal range 1..255)
- CNT_W, 16: width of the stall performance counter

Ports:
- clk_i  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- imem_ready_i  in  1  instruction memory holds valid data for the current PC this cycle
- id_ex_memread_i  in  1  instruction in EX is a load
- id_ex_rt_i  in  5  load destination register in EX
- if_id_rs_i  in  5  rs field of the instruction in ID
- if_id_rt_i  in  5  rt field of the instruction in ID
- md_start_i  in  1  instruction in ID is a mult/div
- branch_taken_i  in  1  taken branch resolved this cycle
- stall_clr_i  in  1  synchronous clear of the stall counter
- pc_write_o  out  1  PC register load enable
- ii_write_o  out  1  IF/ID write enable (drives IIWrite)
- if_id_flush_o  out  1  load zero (NOP) into IF/ID on this edge
- id_ex_bubble_o  out  1  load zero control into ID/EX on this edge
- md_busy_o  out  1  high while in MDBUSY
- stall_cnt_o  out  CNT_W  count of cycles with ii_write_o=0

## Operation
- State register has three states: RUN, IMISS, MDBUSY. An 8-bit md_cnt register is also held.
- lu = id_ex_memread_i & (id_ex_rt_i≠0) & (id_ex_rt_i==if_id_rs_i | id_ex_rt_i==if_id_rt_i).
- "Advance" means pc_write=1, ii_write=1, bubble=0, flush=0. "Stall" means pc_write=0, ii_write=0, bubble=1, flush=0.
- In RUN, the first matching condition wins:
  1. branch_taken_i: pc_write=1, ii_write=1, flush=1, bubble=1. Stay in RUN. md_start_i is ignored.
  2. !imem_ready_i: stall, then go to IMISS.
  3. lu: stall for one cycle. Stay in RUN. md_start_i is ignored.
  4. md_start_i: advance (the mult/div enters EX), then go to MDBUSY with md_cnt←MD_LATENCY.
  5. Otherwise: advance.
- In IMISS:
  - branch_taken_i: pc_write=1, ii_write=1, flush=1, bubble=1.
  - Else if imem_ready_i: advance.
  - Else: stall.
  - Go to RUN when imem_ready_i is high; otherwise stay in IMISS.
- In MDBUSY:
  - Stall every cycle and decrement md_cnt.
  - When md_cnt==1, go to RUN (md_cnt←0).
  - branch_taken_i asserts flush=1 only. The stall outputs are unchanged and the state is unaffected.
- md_busy_o = (state==MDBUSY).
- Stall counter:
  - Increments on every edge where ii_write_o==0.
  - Saturates at 2^CNT_W−1.
  - stall_clr_i has priority over the increment: the counter goes to 0.
- While rst_n is low, all outputs are forced to 0. On reset, state←RUN, md_cnt←0, stall_cnt←0. Reset mid-MDBUSY or mid-IMISS abandons the operation; no pending stall survives.

## Timing
- pc_write_o, ii_write_o, if_id_flush_o and id_ex_bubble_o are combinational from state and inputs. They act on the same rising edge.
- State, md_cnt and stall_cnt update on the rising clock edge.
- Load-use costs exactly 1 bubble cycle. lu is deasserted the following cycle because EX then holds the bubble.
- A mult/div in RUN costs exactly MD_LATENCY stall cycles, counted after the issue cycle.
- An imem wait of N cycles with imem_ready_i low costs N stall cycles. Advance occurs in the cycle imem_ready_i rises.
- A taken branch costs one flushed slot. There is no extra stall.
- Simultaneous branch_taken_i and stall_clr_i are independent; both take effect.

## Test plan
- Reset then idle: rst_n low for 3 cycles → all outputs 0. After release with imem_ready_i=1 and no hazards → pc_write=ii_write=1, bubble=flush=0, stall_cnt stays 0.
- Load-use: id_ex_memread_i=1, id_ex_rt_i=5, if_id_rs_i=5 for one cycle → exactly one cycle with pc_write=ii_write=0 and bubble=1, then advance; stall_cnt=1. Repeating with id_ex_rt_i=0 → no stall.
- Mult/div with MD_LATENCY=4: md_start_i pulse → issue cycle advances, md_busy_o high for 4 cycles with stall, then RUN; stall_cnt=4. A branch_taken_i in the 2nd busy cycle → flush=1 that cycle and busy length still 4.
- Imem wait: imem_ready_i low for 3 cycles → 3 stall cycles with state IMISS, advance on the ready cycle; stall_cnt=3. A branch_taken_i on the 2nd low cycle → flush=1, pc_write=1, and the state remains IMISS.
- Priority: branch_taken_i, lu and md_start_i all asserted in RUN → flush=1, pc_write=1, no MDBUSY entry. lu and md_start_i together → 1 bubble, no MDBUSY.
- Counter edges: with CNT_W=4 and 20 stall cycles → stall_cnt_o saturates at 15. stall_clr_i during a stall → 0. Asserting rst_n low mid-MDBUSY → md_busy_o=0 and state returns to RUN after release.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: five-stage pipeline sequencing controller and stall-cycle counter
// Ports:
//   clk_i, rst_n        clock (rising edge), asynchronous active-low reset
//   imem_ready_i        instruction memory holds valid data for the current PC
//   id_ex_memread_i     instruction in EX is a load
//   id_ex_rt_i          load destination register in EX
//   if_id_rs_i/rt_i     source fields of the instruction in ID
//   md_start_i          instruction in ID is a mult/div
//   branch_taken_i      taken branch resolved this cycle
//   stall_clr_i         synchronous clear of the stall counter
//   pc_write_o          PC load enable
//   ii_write_o          IF/ID write enable
//   if_id_flush_o       load NOP into IF/ID
//   id_ex_bubble_o      load zero control into ID/EX
//   md_busy_o           mult/div occupancy in progress
//   stall_cnt_o         saturating count of cycles with ii_write_o low
module pipe_hazard_ctrl #(
   parameter int unsigned MD_LATENCY = 32,
   parameter int unsigned CNT_W      = 16
) (
   input  logic             clk_i,
   input  logic             rst_n,
   input  logic             imem_ready_i,
   input  logic             id_ex_memread_i,
   input  logic [4:0]       id_ex_rt_i,
   input  logic [4:0]       if_id_rs_i,
   input  logic [4:0]       if_id_rt_i,
   input  logic             md_start_i,
   input  logic             branch_taken_i,
   input  logic             stall_clr_i,
   output logic             pc_write_o,
   output logic             ii_write_o,
   output logic             if_id_flush_o,
   output logic             id_ex_bubble_o,
   output logic             md_busy_o,
   output logic [CNT_W-1:0] stall_cnt_o
);
   typedef enum logic [1:0] {RUN, IMISS, MDBUSY} state_e;
   localparam logic [7:0] MD_LAT = 8'(MD_LATENCY);
   state_e           state_q, state_d;
   logic [7:0]       md_cnt_q, md_cnt_d;
   logic [CNT_W-1:0] stall_cnt_q;
   logic             pc_w, ii_w, flush, bubble, lu;
   assign lu = id_ex_memread_i & (id_ex_rt_i != 5'd0) &
               ((id_ex_rt_i == if_id_rs_i) | (id_ex_rt_i == if_id_rt_i));
   always_comb begin
      state_d  = state_q;
      md_cnt_d = md_cnt_q;
      pc_w     = 1'b1;
      ii_w     = 1'b1;
      flush    = 1'b0;
      bubble   = 1'b0;
      case (state_q)
         RUN: begin
            if (branch_taken_i) begin
               flush  = 1'b1;
               bubble = 1'b1;
            end else if (!imem_ready_i) begin
               {pc_w, ii_w, bubble} = 3'b001;
               state_d = IMISS;
            end else if (lu) begin
               {pc_w, ii_w, bubble} = 3'b001;
            end else if (md_start_i) begin
               state_d  = MDBUSY;
               md_cnt_d = MD_LAT;
            end
         end
         IMISS: begin
            if (branch_taken_i) begin
               flush  = 1'b1;
               bubble = 1'b1;
            end else if (!imem_ready_i) begin
               {pc_w, ii_w, bubble} = 3'b001;
            end
            state_d = imem_ready_i ? RUN : IMISS;
         end
         MDBUSY: begin
            {pc_w, ii_w, bubble} = 3'b001;
            // a branch here only squashes IF/ID; the occupancy countdown continues
            flush    = branch_taken_i;
            md_cnt_d = (md_cnt_q == 8'd1) ? 8'd0 : md_cnt_q - 8'd1;
            state_d  = (md_cnt_q == 8'd1) ? RUN : MDBUSY;
         end
         default: state_d = RUN;
      endcase
   end
   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= RUN;
         md_cnt_q    <= 8'd0;
         stall_cnt_q <= '0;
      end else begin
         state_q  <= state_d;
         md_cnt_q <= md_cnt_d;
         if (stall_clr_i)
            stall_cnt_q <= '0;
         else if (!ii_w && stall_cnt_q != '1)
            stall_cnt_q <= stall_cnt_q + 1'b1;
      end
   end
   assign pc_write_o     = rst_n & pc_w;
   assign ii_write_o     = rst_n & ii_w;
   assign if_id_flush_o  = rst_n & flush;
   assign id_ex_bubble_o = rst_n & bubble;
   assign md_busy_o      = rst_n & (state_q == MDBUSY);
   assign stall_cnt_o    = rst_n ? stall_cnt_q : '0;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed scoreboard bench for pipe_hazard_ctrl (MD_LATENCY=4, CNT_W=4)
module tb_pipe_hazard_ctrl;
   logic       clk_i = 1'b0, rst_n = 1'b0;
   logic       imem_ready_i = 1'b1, id_ex_memread_i = 1'b0, md_start_i = 1'b0;
   logic       branch_taken_i = 1'b0, stall_clr_i = 1'b0;
   logic [4:0] id_ex_rt_i = '0, if_id_rs_i = '0, if_id_rt_i = '0;
   logic       pc_write_o, ii_write_o, if_id_flush_o, id_ex_bubble_o, md_busy_o;
   logic [3:0] stall_cnt_o;
   typedef struct {
      logic [3:0] o;
      logic       busy;
      logic [3:0] cnt;
      string      tag;
   } exp_t;
   exp_t       sb[$];
   int         vectors = 0, errors = 0;
   logic [3:0] exp_cnt = '0;
   // {pc_write, ii_write, flush, bubble}
   localparam logic [3:0] ADV = 4'b1100, STL = 4'b0001, BR = 4'b1111, MDB = 4'b0011, OFF = 4'b0000;
   pipe_hazard_ctrl #(.MD_LATENCY(4), .CNT_W(4)) dut (
      .clk_i(clk_i), .rst_n(rst_n), .imem_ready_i(imem_ready_i),
      .id_ex_memread_i(id_ex_memread_i), .id_ex_rt_i(id_ex_rt_i),
      .if_id_rs_i(if_id_rs_i), .if_id_rt_i(if_id_rt_i), .md_start_i(md_start_i),
      .branch_taken_i(branch_taken_i), .stall_clr_i(stall_clr_i),
      .pc_write_o(pc_write_o), .ii_write_o(ii_write_o), .if_id_flush_o(if_id_flush_o),
      .id_ex_bubble_o(id_ex_bubble_o), .md_busy_o(md_busy_o), .stall_cnt_o(stall_cnt_o)
   );
   always #5 clk_i = ~clk_i;
   task automatic step(input logic r, imem, mr, input logic [4:0] ert, rs, rt,
                       input logic md, br, clr, input logic [3:0] eo, input logic busy,
                       input string tag);
      exp_t e, g;
      logic [3:0] obs;
      @(negedge clk_i);
      rst_n = r; imem_ready_i = imem; id_ex_memread_i = mr; id_ex_rt_i = ert;
      if_id_rs_i = rs; if_id_rt_i = rt; md_start_i = md; branch_taken_i = br; stall_clr_i = clr;
      if (!r) exp_cnt = '0;
      e.o = eo; e.busy = busy; e.cnt = exp_cnt; e.tag = tag;
      sb.push_back(e);
      #1;
      g = sb.pop_front();
      obs = {pc_write_o, ii_write_o, if_id_flush_o, id_ex_bubble_o};
      vectors++;
      assert (obs === g.o) else begin
         errors++;
         $error("FAIL %s ctrl {pc,ii,flush,bubble} observed=%b expected=%b", g.tag, obs, g.o);
      end
      vectors++;
      assert (md_busy_o === g.busy) else begin
         errors++;
         $error("FAIL %s md_busy observed=%b expected=%b", g.tag, md_busy_o, g.busy);
      end
      vectors++;
      assert (stall_cnt_o === g.cnt) else begin
         errors++;
         $error("FAIL %s stall_cnt observed=%0d expected=%0d", g.tag, stall_cnt_o, g.cnt);
      end
      if (!r || clr) exp_cnt = '0;
      else if (!eo[2] && exp_cnt != 4'hf) exp_cnt = exp_cnt + 4'd1;
   endtask
   task automatic idle(input int n, input logic busy, input string tag);
      for (int i = 0; i < n; i++) step(1, 1, 0, 0, 0, 0, 0, 0, 0, ADV, busy, tag);
   endtask
   task automatic busy_stall(input int n, input string tag);
      for (int i = 0; i < n; i++) step(1, 1, 0, 0, 0, 0, 0, 0, 0, STL, 1, tag);
   endtask
   initial begin
      for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0, 0, 0, 0, 0, OFF, 0, "reset");
      idle(3, 0, "idle");
      step(1, 1, 1, 5, 5, 0, 0, 0, 0, STL, 0, "lu_rs");
      idle(1, 0, "lu_after");
      step(1, 1, 1, 0, 0, 0, 0, 0, 0, ADV, 0, "lu_r0");
      step(1, 1, 1, 7, 3, 7, 0, 0, 0, STL, 0, "lu_rt");
      step(1, 1, 1, 5, 6, 7, 0, 0, 0, ADV, 0, "lu_nomatch");
      step(1, 1, 0, 0, 0, 0, 1, 0, 0, ADV, 0, "md_issue");
      busy_stall(4, "md_busy");
      idle(1, 0, "md_done");
      step(1, 1, 0, 0, 0, 0, 1, 0, 0, ADV, 0, "md2_issue");
      busy_stall(1, "md2_busy1");
      step(1, 1, 0, 0, 0, 0, 0, 1, 0, MDB, 1, "md2_branch");
      busy_stall(2, "md2_busy34");
      idle(1, 0, "md2_done");
      for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 0, 0, 0, 0, STL, 0, "imiss");
      idle(2, 0, "imiss_ready");
      step(1, 0, 0, 0, 0, 0, 0, 0, 0, STL, 0, "imiss2_low1");
      step(1, 0, 0, 0, 0, 0, 0, 1, 0, BR, 0, "imiss2_branch");
      // still IMISS: md_start on the ready cycle must not enter MDBUSY
      step(1, 1, 0, 0, 0, 0, 1, 0, 0, ADV, 0, "imiss2_ready");
      idle(1, 0, "imiss2_run");
      step(1, 1, 1, 5, 5, 0, 1, 1, 0, BR, 0, "prio_all");
      idle(1, 0, "prio_all_after");
      step(1, 1, 1, 5, 5, 0, 1, 0, 0, STL, 0, "prio_lu_md");
      idle(1, 0, "prio_lu_md_after");
      step(1, 1, 1, 9, 9, 0, 0, 0, 1, STL, 0, "clr_in_stall");
      idle(1, 0, "clr_after");
      for (int i = 0; i < 20; i++) step(1, 0, 0, 0, 0, 0, 0, 0, 0, STL, 0, "sat");
      idle(1, 0, "sat_hold");
      step(1, 1, 0, 0, 0, 0, 0, 1, 1, BR, 0, "br_clr");
      idle(1, 0, "br_clr_after");
      step(1, 1, 0, 0, 0, 0, 1, 0, 0, ADV, 0, "rst_md_issue");
      busy_stall(2, "rst_md_busy");
      step(0, 1, 0, 0, 0, 0, 0, 0, 0, OFF, 0, "rst_mid_md");
      idle(3, 0, "rst_release");
      step(1, 0, 0, 0, 0, 0, 0, 0, 0, STL, 0, "rst_imiss_low");
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, OFF, 0, "rst_mid_imiss");
      step(1, 1, 0, 0, 0, 0, 1, 0, 0, ADV, 0, "rst_imiss_run");
      busy_stall(1, "rst_imiss_md");
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule
